// File: rtl/wb_regfile_if.sv
// Writeback / register-read bundle between the pipeline and wb_regfile.
// The master side drives the MEM/WB and ID-stage inputs; the slave is the register file.
interface wb_regfile_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [31:0]            read_data_input;
    logic [31:0]            alu_result_input;
    logic [4:0]             write_register_input;
    logic [1:0]             WB_input;
    logic [4:0]             read_register1;
    logic [4:0]             read_register2;
    logic [31:0]            read_data1;
    logic [31:0]            read_data2;
    logic [31:0]            write_data_output;
    logic [COUNT_WIDTH-1:0] write_count;

    modport master (
        output read_data_input, alu_result_input, write_register_input, WB_input,
        output read_register1, read_register2,
        input  read_data1, read_data2, write_data_output, write_count
    );

    modport slave (
        input  read_data_input, alu_result_input, write_register_input, WB_input,
        input  read_register1, read_register2,
        output read_data1, read_data2, write_data_output, write_count
    );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 register file with writeback mux and saturating retired-write counter.
// Optional macro WB_BYPASS_EN adds same-cycle write-to-read bypass on both read ports.
module wb_regfile #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic          clock,
    input  logic          startin,
    wb_regfile_if.slave   wb
);

    logic [31:0]            regs_q [31:1];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [31:0]            wdata;
    logic                   wr_en;
    logic [31:0]            rd1;
    logic [31:0]            rd2;

    assign wdata = wb.WB_input[0] ? wb.read_data_input : wb.alu_result_input;
    assign wr_en = wb.WB_input[1] && (wb.write_register_input != 5'd0) && !startin;

    // Counter stops at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (wr_en && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wb.write_register_input] <= wdata;
            end
            count_q <= count_d;
        end
    end

    // Reads are forced to zero during reset and for index 0.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!startin) begin
            if (wb.read_register1 != 5'd0) begin
                rd1 = regs_q[wb.read_register1];
            end
            if (wb.read_register2 != 5'd0) begin
                rd2 = regs_q[wb.read_register2];
            end
`ifdef WB_BYPASS_EN
            if (wr_en && (wb.write_register_input == wb.read_register1)) begin
                rd1 = wdata;
            end
            if (wr_en && (wb.write_register_input == wb.read_register2)) begin
                rd2 = wdata;
            end
`endif
        end
    end

    assign wb.read_data1        = rd1;
    assign wb.read_data2        = rd2;
    assign wb.write_data_output = wdata;
    assign wb.write_count       = count_q;

`ifndef SYNTHESIS
    // An unknown RegWrite would make the write decision meaningless.
    regWriteKnown: assert property (@(posedge clock) disable iff (startin)
                                    !$isunknown(wb.WB_input[1]));
`endif

endmodule
